// File: rtl/mdu_ctrl_pkg.sv
// Shared MDU op encodings, latency defaults and the HI/LO pair type.
// Imported by the controller and by anything that issues MDU operations.
package mdu_ctrl_pkg;

  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MTHI  = 4'd5;
  localparam logic [3:0] MDU_MTLO  = 4'd6;
  localparam logic [3:0] MDU_MFHI  = 4'd7;
  localparam logic [3:0] MDU_MFLO  = 4'd8;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// E-stage <-> MDU bundle: start/op/operands in, busy/stall/HI/LO/read data out.
// master = pipeline side, slave = mdu_ctrl.
interface mdu_ctrl_if;
  logic        mdu_start;
  logic [3:0]  mdu_op;
  logic        kill;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        mdu_use_D;
  logic        busy;
  logic        stall_D;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mdu_rd_E;

  modport master (
    output mdu_start, mdu_op, kill, src_a, src_b, mdu_use_D,
    input  busy, stall_D, hi, lo, mdu_rd_E
  );

  modport slave (
    input  mdu_start, mdu_op, kill, src_a, src_b, mdu_use_D,
    output busy, stall_D, hi, lo, mdu_rd_E
  );
endinterface

// File: rtl/mdu_timer.sv
// Busy down-counter: load starts an N-cycle busy window, done pulses on its last cycle.
// Latency N edges from load to busy falling; a load while busy is not expected.
module mdu_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             busy,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  assign done = busy & (cnt == CNT_W'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else if (load) begin
      cnt  <= load_val;
      busy <= 1'b1;
    end else if (done) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else if (busy) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// MIPS multiply/divide controller owning HI/LO; mul/div commit after MULT/DIV_CYCLES, MT* next edge.
// No backpressure on E: starts during busy are dropped and stall_D holds D until the unit is free.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  mdu_ctrl_if.slave  mdu
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic             busy;
  logic             done;
  logic             accept;
  logic             start_md;
  logic             op_div;
  logic             div_zero;
  logic [CNT_W-1:0] load_val;

  logic [31:0] opa, opb;
  logic        mul_signed, div_signed;
  logic [63:0] prod;
  logic [31:0] mag_a, mag_b, divisor, quot, rem;

  hilo_t md_res;
  hilo_t pending;
  hilo_t arch;
  logic  pending_zero;

  assign opa      = mdu.src_a;
  assign opb      = mdu.src_b;
  assign accept   = mdu.mdu_start & ~mdu.kill & ~busy;
  assign start_md = accept & is_muldiv(mdu.mdu_op);
  assign op_div   = (mdu.mdu_op == MDU_DIV) || (mdu.mdu_op == MDU_DIVU);
  assign div_zero = (opb == '0);
  assign load_val = op_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

  // Signed divide runs on magnitudes so INT_MIN / -1 wraps to 0x80000000 without a special case.
  always_comb begin
    mul_signed = (mdu.mdu_op == MDU_MULT);
    div_signed = (mdu.mdu_op == MDU_DIV);
    prod    = {{32{mul_signed & opa[31]}}, opa} * {{32{mul_signed & opb[31]}}, opb};
    mag_a   = (div_signed & opa[31]) ? -opa : opa;
    mag_b   = (div_signed & opb[31]) ? -opb : opb;
    divisor = div_zero ? 32'd1 : mag_b;
    quot    = mag_a / divisor;
    rem     = mag_a % divisor;
    md_res  = prod;
    if (op_div) begin
      md_res.lo = (div_signed & (opa[31] ^ opb[31])) ? -quot : quot;
      md_res.hi = (div_signed & opa[31]) ? -rem : rem;
    end
  end

  mdu_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (start_md),
    .load_val (load_val),
    .busy     (busy),
    .done     (done)
  );

  // done only fires while busy and accept needs ~busy, so commit and MT* never collide.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      arch         <= '0;
      pending      <= '0;
      pending_zero <= 1'b0;
    end else begin
      if (start_md) begin
        pending      <= md_res;
        pending_zero <= op_div & div_zero;
      end
      if (done && !pending_zero) begin
        arch <= pending;
      end else if (accept && (mdu.mdu_op == MDU_MTHI)) begin
        arch.hi <= opa;
      end else if (accept && (mdu.mdu_op == MDU_MTLO)) begin
        arch.lo <= opa;
      end
    end
  end

  always_comb begin
    mdu.mdu_rd_E = '0;
    if (mdu.mdu_op == MDU_MFHI) begin
      mdu.mdu_rd_E = arch.hi;
    end else if (mdu.mdu_op == MDU_MFLO) begin
      mdu.mdu_rd_E = arch.lo;
    end
  end

  assign mdu.busy    = busy;
  assign mdu.stall_D = mdu.mdu_use_D & (busy | start_md);
  assign mdu.hi      = arch.hi;
  assign mdu.lo      = arch.lo;

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multiply/divide unit controller for the five-stage MIPS pipeline. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO operations from the E stage and owns the architectural HI/LO registers. It models multiply and divide latency with a down-counter, and drives the D-stage stall request to the hazard unit. It also honours exception/interrupt flushes so that a killed E-stage instruction never changes HI/LO.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU
- DIV_CYCLES, 10, busy cycles for DIV/DIVU

Ports:
- clk  input  1  pipeline clock, rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset)
- mdu_start  input  1  valid MDU instruction present in E this cycle
- mdu_op  input  4  operation code; encodings `MDU_MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO`
- kill  input  1  flush of the E-stage instruction (exception or interrupt); overrides mdu_start
- src_a  input  32  rs operand, forwarded
- src_b  input  32  rt operand, forwarded
- mdu_use_D  input  1  instruction in D is any MDU operation
- busy  output  1  multiply/divide in flight
- stall_D  output  1  stall request to the hazard unit
- hi  output  32  architectural HI
- lo  output  32  architectural LO
- mdu_rd_E  output  32  MFHI → hi, MFLO → lo, otherwise 0; combinational

## Operation
- Accept condition: accept = mdu_start & ~kill & ~busy.
- MULT/MULTU/DIV/DIVU accepted:
  - Compute the 64-bit result combinationally from src_a/src_b and latch it into pending_hi/pending_lo.
  - Load the counter with MULT_CYCLES or DIV_CYCLES.
  - Set busy.
- While busy, decrement the counter each cycle. When it reaches 1:
  - Commit pending values to HI/LO.
  - Clear busy.
- MULT: {hi,lo} = signed product. MULTU: unsigned product.
- DIV: lo = quotient truncated toward zero; hi = remainder, carrying the sign of the dividend. DIVU: unsigned quotient and remainder.
- DIV of 0x80000000 by 0xFFFFFFFF gives lo=0x80000000, hi=0.
- Divisor 0 (DIV or DIVU): full DIV_CYCLES busy period, but HI/LO keep their previous values.
- MTHI/MTLO accepted: write src_a to hi or lo at the next edge; no busy.
- MFHI/MFLO: read only, no state change.
- mdu_start with busy=1: ignored. The hazard unit prevents this; the bench checks HI/LO are unaffected.
- kill during a busy period does not abort the operation in flight; it was already committed past E.
- stall_D = mdu_use_D & (busy | (accept & op is MULT/MULTU/DIV/DIVU)).

## Timing
- Reset (reset=0, asynchronous):
  - hi = lo = 0, busy = 0, counter = 0, pending_hi = pending_lo = 0.
  - stall_D = 0 whenever busy=0 and no accept.
- Reset asserted mid-operation: the operation is discarded and HI/LO return to 0 immediately.
- Multiply/divide start accepted at edge t0:
  - busy = 1 from t0 to t0+N, where N = MULT_CYCLES or DIV_CYCLES.
  - HI/LO update and busy falls at edge t0+N.
  - busy is high for exactly N cycles.
- A new multiply/divide is accepted at edge t0+N+1 at the earliest, i.e. the first edge after busy falls.
- MFHI in the cycle after busy falls reads the new value.
- MTHI/MTLO accepted at edge t0: hi/lo show the new value after t0.
- mdu_rd_E: zero-cycle combinational path from hi/lo.
- stall_D asserts in the same cycle as an accepting start when mdu_use_D=1, with no bubble gap.

## Structure
- MDU op encodings go in the shared MACRO.v alongside the ALU op macros: `MDU_MULT 4'd1`, `MDU_MULTU 4'd2`, `MDU_DIV 4'd3`, `MDU_DIVU 4'd4`, `MDU_MTHI 4'd5`, `MDU_MTLO 4'd6`, `MDU_MFHI 4'd7`, `MDU_MFLO 4'd8`.
- Latency defaults also go in MACRO.v.
- One natural sub-module: mdu_timer, covering counter load, decrement and done pulse.
- Arithmetic and HI/LO state stay in mdu_ctrl.

## Test plan
- MULT: src_a=0xFFFFFFFE, src_b=3 → busy high for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands → hi=0x2, lo=0xFFFFFFFA.
- DIV: src_a=0xFFFFFFF9 (-7), src_b=2 → busy high for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/0 → busy for 10 cycles, HI/LO unchanged.
- MULT with kill=1 in the start cycle → busy stays 0, HI/LO unchanged, stall_D=0. MTLO 0x1234 with kill=1 → lo unchanged.
- DIV started, mdu_use_D=1 held → stall_D=1 for cycles t0..t0+9. MFLO accepted at t0+10 returns the quotient on mdu_rd_E.
- reset driven to 0 at cycle 3 of a DIV → hi=lo=0 and busy=0 asynchronously. After release, MTHI 0xA5A5A5A5 → hi=0xA5A5A5A5 next cycle.
- Back-to-back: MULT accepted, second MULT held on mdu_start during busy → second is ignored until busy falls, then accepted at the next edge.
